imem_loader: RTL

//  Boot-time writer for instruction memory: accepts a byte stream (valid/ready), assembles little-endian
//  32-bit words and drives a word write port into instruction RAM. Holds the core in reset while loading.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader_byte_packer.sv | 35 +++
 rtl/imem_loader.sv | 138 +++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and sizes for the instruction-memory boot loader.
// Optional checksum trailer is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = BYTE_W * WORD_BYTES;
    localparam int LANE_W     = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream, RAM write port and load control/status bundle of the boot loader.
// master = the loader itself, slave = host link / RAM / core control side.
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic              start;
    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       words_loaded;

    modport master (
        input  start, in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata,
        output cpu_hold, busy, done, err, words_loaded
    );

    modport slave (
        output start, in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata,
        input  cpu_hold, busy, done, err, words_loaded
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Little-endian 8->32 assembler: the first byte of a word lands in bits [7:0].
// word_o/word_valid_o are combinational on the byte that completes a word.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear_i,
    input  logic [BYTE_W-1:0] byte_i,
    input  logic              byte_valid_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o
);
    logic [LANE_W-1:0]        lane_q;
    logic [WORD_W-BYTE_W-1:0] low_q;

    always_ff @(posedge clk) begin
        if (!reset_n || clear_i) begin
            lane_q <= '0;
            low_q  <= '0;
        end else if (byte_valid_i) begin
            lane_q <= lane_q + 1'b1;
            for (int i = 0; i < WORD_BYTES - 1; i++) begin
                if (lane_q == LANE_W'(i)) begin
                    low_q[i*BYTE_W +: BYTE_W] <= byte_i;
                end
            end
        end
    end

    // The top byte is never stored: it completes the word in the same cycle.
    assign word_o       = {byte_i, low_q};
    assign word_valid_o = byte_valid_i && (lane_q == LANE_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction RAM writer: header count, N little-endian words, optional
// checksum trailer (IMEM_LOADER_CHECKSUM_EN). Keeps the core held until a clean load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 2097152
) (
    input  logic          clk,
    input  logic          reset_n,
    imem_loader_if.master bus
);
    state_e            state_q;
    logic              in_ready_q, mem_we_q, cpu_hold_q, busy_q, done_q, err_q;
    logic [31:0]       mem_addr_q, words_q, count_q;
    logic [WORD_W-1:0] mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum_q;
`endif

    logic              accept, start_ok, last_word, word_valid, finish_d, fail_d;
    logic [WORD_W-1:0] word;

    assign accept    = bus.in_valid && in_ready_q;
    assign start_ok  = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign last_word = (words_q + 32'd1) == count_q;

    byte_packer u_packer (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear_i      (start_ok),
        .byte_i       (bus.in_data),
        .byte_valid_i (accept),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    always_comb begin
        finish_d = 1'b0;
        fail_d   = 1'b0;
        if (word_valid) begin
            case (state_q)
                ST_HDR: begin
                    if (word == '0) begin
                        finish_d = 1'b1;
                    end else if (word > MAX_WORDS) begin
                        finish_d = 1'b1;
                        fail_d   = 1'b1;
                    end
                end
                ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    finish_d = 1'b0;
`else
                    finish_d = last_word;
`endif
                end
                ST_CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    finish_d = 1'b1;
                    fail_d   = (word != sum_q);
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_hold_q  <= 1'b1;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
            words_q     <= '0;
            count_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            if (start_ok) begin
                state_q    <= ST_HDR;
                in_ready_q <= 1'b1;
                busy_q     <= 1'b1;
                done_q     <= 1'b0;
                err_q      <= 1'b0;
                cpu_hold_q <= 1'b1;
                words_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_q      <= '0;
`endif
            end else if (finish_d) begin
                state_q    <= ST_DONE;
                in_ready_q <= 1'b0;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                err_q      <= fail_d;
                cpu_hold_q <= fail_d;
            end else if (word_valid && state_q == ST_HDR) begin
                state_q <= ST_DATA;
                count_q <= word;
`ifdef IMEM_LOADER_CHECKSUM_EN
            end else if (word_valid && state_q == ST_DATA && last_word) begin
                state_q <= ST_CSUM;
`endif
            end

            // Data words are written independently of the state change so the
            // final word's strobe coincides with entering DONE/CSUM.
            if (word_valid && state_q == ST_DATA) begin
                mem_we_q    <= 1'b1;
                mem_addr_q  <= BASE_ADDR + {words_q[29:0], 2'b00};
                mem_wdata_q <= word;
                words_q     <= words_q + 32'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_q       <= sum_q + word;
`endif
            end
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.cpu_hold     = cpu_hold_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.words_loaded = words_q;

endmodule
